imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the instruction memory read by the fetch stage. It consumes a byte stream with a ready/valid handshake, checks and unpacks a small header, packs big-endian 32-bit words, and issues word writes to the instruction-memory write port. It holds the pipeline frozen until the image is complete, then releases it with the load address as the boot PC.

## Interface
- `ADDR_W`, 32: width of byte addresses and `boot_pc`.
- `MAX_WORDS`, 1024: largest accepted word count. A count above this is an error.
- `clk` in 1: single clock. Everything is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that aborts any load and restarts header reception.
- `in_valid` in 1: a byte is offered.
- `in_data` in 8: the offered byte.
- `in_ready` out 1: the loader accepts a byte. A byte is accepted when `in_valid && in_ready`.
- `wr_en` out 1: one-cycle instruction-memory write strobe.
- `wr_addr` out ADDR_W: byte address of the word being written, word-aligned.
- `wr_data` out 32: the instruction word.
- `boot_pc` out ADDR_W: the header start address, valid while `done` is high.
- `core_hold` out 1: while high, the pipeline PC and pipeline registers are frozen.
- `done` out 1: the image loaded successfully.
- `error` out 1: the load failed. Sticky until `start` or reset.
- `err_code` out 2: 0 = none, 1 = misaligned start address, 2 = count greater than MAX_WORDS, 3 = checksum mismatch.

## Operation
- Stream format, all fields big-endian:
  - start address, 4 bytes;
  - word count, 2 bytes;
  - count × 4 instruction bytes;
  - when `LOADER_CHECKSUM_EN` is defined, one checksum byte.
- States: ADDR, COUNT, DATA, CHECK, DONE, ERR. Reset enters ADDR.
- ADDR: shift in 4 bytes.
  - On the 4th byte, if address[1:0] ≠ 0, go to ERR with code 1.
  - Otherwise go to COUNT.
- COUNT: shift in 2 bytes.
  - count > MAX_WORDS: go to ERR with code 2.
  - count = 0: go to CHECK (or straight to DONE when the checksum is compiled out). No writes are issued.
  - Otherwise go to DATA.
- DATA: a byte counter (0–3) and a word counter run.
  - Every 4th accepted byte produces one write at the current address.
  - The address then advances by 4, modulo 2^ADDR_W.
  - After word `count` is written, go to CHECK or DONE.
- CHECK: accept 1 byte. If it equals the running XOR of all data bytes, go to DONE; otherwise go to ERR with code 3.
- DONE and ERR are terminal. `in_ready` is 0 in both; only `start` or reset leaves them.
- `start` in any state:
  - returns to ADDR;
  - clears all counters, the XOR accumulator, `done`, `error` and `err_code`;
  - raises `core_hold`.
  - A byte offered in the same cycle is not accepted.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `boot_pc`=0, `core_hold`=1, `done`=0, `error`=0, `err_code`=0, state ADDR.
- All outputs are registered.
- `in_ready` rises the first clock after reset release or after `start`. It falls the cycle after the final byte of a terminal transition is accepted.
- Write latency: if the 4th byte of a word is accepted in cycle N, `wr_en`, `wr_addr` and `wr_data` are valid in cycle N+1 only.
- Release:
  - `done` rises and `core_hold` falls in cycle N+2 after the last accepted byte (the last data byte, or the checksum byte).
  - This guarantees the final write completes before fetch resumes.
  - When the count is 0 and the checksum is compiled out, the last accepted byte is the 2nd count byte.
- `error` and `err_code` are set in cycle N+1 after the offending byte. `core_hold` stays 1 in ERR.
- Back-to-back bytes at full rate are supported. Gaps in `in_valid` just stall the counters.
- Asynchronous reset mid-load discards the partial word. No `wr_en` is issued for it.

## Configuration
- `LOADER_CHECKSUM_EN` defined: the CHECK state and XOR accumulator are present, and error code 3 is possible.
- Undefined: the stream ends after the last data word, CHECK is never entered, and code 3 never occurs.

## Structure
- Package `imem_loader_pkg` contains:
  - the state enum;
  - `err_code` constants;
  - header byte-length constants (ADDR_BYTES=4, COUNT_BYTES=2).
- Sub-module `byte_packer` is a 4-byte shift assembler with a byte counter. It is instantiated for the address field and for data words.

## Test plan
- Start address 0x000000C8, count 2, bytes 20 08 00 04 and 20 09 00 08:
  - writes (200, 0x20080004) and then (204, 0x20090008);
  - `boot_pc`=200, `done`=1, `core_hold`=0 two cycles after the last byte.
- Start address 0x000000CA → `error`=1, `err_code`=1, no `wr_en`, `core_hold` stays 1, `in_ready`=0.
- Count 0x0401 with MAX_WORDS=1024 → `err_code`=2. Count 0 → `done` with zero writes.
- `start` pulsed after 6 data bytes, then a full valid 1-word image → exactly one write, of the new word. The byte offered in the `start` cycle is ignored.
- Checksum enabled, 1 word 11 22 33 44:
  - checksum byte 0x44 → `done`;
  - checksum byte 0x45 → `err_code`=3.
- Random `in_valid` gaps on the 2-word image → identical writes and `done`. Start address 0xFFFFFFFC with 2 words → second write at address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states, error codes and
// header field sizes.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      StAddr,
      StCount,
      StData,
      StCheck,
      StDone,
      StErr
   } state_e;

   localparam logic [1:0] ErrNone  = 2'd0;
   localparam logic [1:0] ErrAlign = 2'd1;
   localparam logic [1:0] ErrCount = 2'd2;
   localparam logic [1:0] ErrCsum  = 2'd3;

   localparam int unsigned ADDR_BYTES  = 4;
   localparam int unsigned COUNT_BYTES = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four bytes, first byte most significant, into a 32-bit word.
// `word` shows the word as it will look once the byte on `din` is shifted in.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        shift,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic        last
);

   logic [23:0] word_q;
   logic [1:0]  cnt_q;

   assign word = {word_q, din};
   assign last = (cnt_q == 2'(ADDR_BYTES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (clear) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (shift) begin
         word_q <= word[23:0];
         cnt_q  <= cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: unpacks a big-endian header + word stream into instruction-memory writes and
// holds the core until the image is complete. Define LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [ADDR_W-1:0] boot_pc,
   output logic              core_hold,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code
);

`ifdef LOADER_CHECKSUM_EN
   localparam state_e StreamEnd = StCheck;
   localparam logic   EndReady  = 1'b1;
   logic [7:0] xor_q;
`else
   localparam state_e StreamEnd = StDone;
   localparam logic   EndReady  = 1'b0;
`endif

   state_e            state_q;
   logic [ADDR_W-1:0] start_addr_q;
   logic [ADDR_W-1:0] cur_addr_q;
   logic [15:0]       count_q;
   logic [15:0]       word_cnt_q;
   logic [1:0]        cnt_byte_q;
   logic [31:0]       addr_word;
   logic [31:0]       data_word;
   logic              addr_last;
   logic              data_last;
   logic              accept;
   logic [15:0]       count_next;

   // A byte offered alongside start is dropped so the restart begins cleanly.
   assign accept     = in_valid && in_ready && !start;
   assign count_next = {count_q[7:0], in_data};

   byte_packer u_addr_packer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start),
      .shift (accept && (state_q == StAddr)),
      .din   (in_data),
      .word  (addr_word),
      .last  (addr_last)
   );

   byte_packer u_data_packer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start),
      .shift (accept && (state_q == StData)),
      .din   (in_data),
      .word  (data_word),
      .last  (data_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StAddr;
         in_ready     <= 1'b0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         boot_pc      <= '0;
         core_hold    <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         err_code     <= ErrNone;
         start_addr_q <= '0;
         cur_addr_q   <= '0;
         count_q      <= '0;
         word_cnt_q   <= '0;
         cnt_byte_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
         xor_q        <= '0;
`endif
      end else begin
         wr_en <= 1'b0;
         if (start) begin
            state_q    <= StAddr;
            in_ready   <= 1'b1;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ErrNone;
            count_q    <= '0;
            word_cnt_q <= '0;
            cnt_byte_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
         end else begin
            unique case (state_q)
               StAddr: begin
                  in_ready <= 1'b1;
                  if (accept && addr_last) begin
                     if (addr_word[1:0] != 2'b00) begin
                        state_q  <= StErr;
                        in_ready <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ErrAlign;
                     end else begin
                        start_addr_q <= ADDR_W'(addr_word);
                        cur_addr_q   <= ADDR_W'(addr_word);
                        state_q      <= StCount;
                     end
                  end
               end
               StCount: begin
                  in_ready <= 1'b1;
                  if (accept) begin
                     count_q    <= count_next;
                     cnt_byte_q <= cnt_byte_q + 2'd1;
                     if (cnt_byte_q == 2'(COUNT_BYTES - 1)) begin
                        if (32'(count_next) > MAX_WORDS) begin
                           state_q  <= StErr;
                           in_ready <= 1'b0;
                           error    <= 1'b1;
                           err_code <= ErrCount;
                        end else if (count_next == 16'd0) begin
                           state_q  <= StreamEnd;
                           in_ready <= EndReady;
                        end else begin
                           state_q <= StData;
                        end
                     end
                  end
               end
               StData: begin
                  in_ready <= 1'b1;
                  if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                     xor_q <= xor_q ^ in_data;
`endif
                     if (data_last) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= cur_addr_q;
                        wr_data    <= data_word;
                        cur_addr_q <= cur_addr_q + ADDR_W'(4);
                        word_cnt_q <= word_cnt_q + 16'd1;
                        if (word_cnt_q + 16'd1 == count_q) begin
                           state_q  <= StreamEnd;
                           in_ready <= EndReady;
                        end
                     end
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               StCheck: begin
                  in_ready <= 1'b1;
                  if (accept) begin
                     in_ready <= 1'b0;
                     if (in_data == xor_q) begin
                        state_q <= StDone;
                     end else begin
                        state_q  <= StErr;
                        error    <= 1'b1;
                        err_code <= ErrCsum;
                     end
                  end
               end
`endif
               // One cycle in DONE before release lets the final write land ahead of fetch.
               StDone: begin
                  in_ready  <= 1'b0;
                  done      <= 1'b1;
                  core_hold <= 1'b0;
                  boot_pc   <= start_addr_q;
               end
               StErr: begin
                  in_ready <= 1'b0;
               end
               default: begin
                  state_q  <= StAddr;
                  in_ready <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random images against a stream-level reference model.
module tb_imem_loader;

`ifdef LOADER_CHECKSUM_EN
   localparam bit CsumEn = 1'b1;
`else
   localparam bit CsumEn = 1'b0;
`endif
   localparam int unsigned MaxW = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [31:0] boot_pc;
   logic        core_hold;
   logic        done;
   logic        error;
   logic [1:0]  err_code;

   imem_loader #(
      .ADDR_W    (32),
      .MAX_WORDS (MaxW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .boot_pc   (boot_pc),
      .core_hold (core_hold),
      .done      (done),
      .error     (error),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [31:0] img_words[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic [1:0]  exp_code;
   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   int          got_cyc[$];
   int          acc_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         got_addr.push_back(wr_addr);
         got_data.push_back(wr_data);
         got_cyc.push_back(cyc);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: expected writes and outcome computed straight from the stream format.
   function automatic void model(input logic [31:0] addr, input logic [15:0] count,
                                 input bit bad, output logic [7:0] csum);
      logic [7:0] x;
      x = 8'h00;
      csum = 8'h00;
      exp_addr.delete();
      exp_data.delete();
      exp_code = 2'd0;
      if (addr[1:0] != 2'b00) begin
         exp_code = 2'd1;
         return;
      end
      if (count > MaxW) begin
         exp_code = 2'd2;
         return;
      end
      for (int w = 0; w < int'(count); w++) begin
         exp_addr.push_back(addr + 32'(4 * w));
         exp_data.push_back(img_words[w]);
         x ^= img_words[w][31:24] ^ img_words[w][23:16] ^ img_words[w][15:8] ^ img_words[w][7:0];
      end
      csum = bad ? (x ^ 8'h01) : x;
      if (CsumEn && bad) exp_code = 2'd3;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int waits;
      waits = 0;
      if (gaps) begin
         while ($urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      if (in_ready !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL send_byte: in_ready stayed %b, want 1", in_ready);
      end else begin
         acc_cyc.push_back(cyc);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
      acc_cyc.delete();
   endtask

   task automatic drive_image(input logic [31:0] addr, input logic [15:0] count,
                              input logic [7:0] csum, input bit gaps);
      for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8], gaps);
      if (addr[1:0] != 2'b00) return;
      send_byte(count[15:8], gaps);
      send_byte(count[7:0], gaps);
      if (count > MaxW) return;
      for (int w = 0; w < int'(count); w++)
         for (int i = 3; i >= 0; i--) send_byte(img_words[w][8*i +: 8], gaps);
      if (CsumEn) send_byte(csum, gaps);
   endtask

   task automatic test_image(input string name, input logic [31:0] addr, input logic [15:0] count,
                             input bit gaps, input bit bad);
      logic [7:0] csum;
      int         n;
      @(negedge clk);
      model(addr, count, bad, csum);
      pulse_start();
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s in_ready after start: got %b want 1", name, in_ready);
      end
      vectors++;
      if ({core_hold, done, error, err_code} !== 5'b10000) begin
         miscompares++;
         $display("FAIL %s status after start: got hold/done/err/code %b%b%b%0d want 1000",
                  name, core_hold, done, error, err_code);
      end
      drive_image(addr, count, csum, gaps);
      if (exp_code == 2'd0) begin
         vectors++;
         if ({done, core_hold, in_ready} !== 3'b010) begin
            miscompares++;
            $display("FAIL %s N+1 done/hold/ready: got %b%b%b want 010", name, done, core_hold,
                     in_ready);
         end
         @(negedge clk);
         vectors++;
         if ({done, core_hold, error, err_code} !== 5'b10000) begin
            miscompares++;
            $display("FAIL %s N+2 done/hold/err/code: got %b%b%b%0d want 1000", name, done,
                     core_hold, error, err_code);
         end
         vectors++;
         if (boot_pc !== addr) begin
            miscompares++;
            $display("FAIL %s boot_pc: got %h want %h", name, boot_pc, addr);
         end
      end else begin
         vectors++;
         if ({error, err_code, core_hold, in_ready, done} !== {1'b1, exp_code, 3'b100}) begin
            miscompares++;
            $display("FAIL %s N+1 err/code/hold/ready/done: got %b%0d%b%b%b want 1%0d100", name,
                     error, err_code, core_hold, in_ready, done, exp_code);
         end
      end
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if (got_addr.size() != exp_addr.size()) begin
         miscompares++;
         $display("FAIL %s write count: got %0d want %0d", name, got_addr.size(), exp_addr.size());
      end
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         vectors++;
         if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
            miscompares++;
            $display("FAIL %s write %0d: got (%h,%h) want (%h,%h)", name, i, got_addr[i],
                     got_data[i], exp_addr[i], exp_data[i]);
         end
         if (6 + 4 * i + 3 < acc_cyc.size()) begin
            vectors++;
            if (got_cyc[i] != acc_cyc[6 + 4 * i + 3] + 1) begin
               miscompares++;
               $display("FAIL %s write %0d cycle: got %0d want %0d", name, i, got_cyc[i],
                        acc_cyc[6 + 4 * i + 3] + 1);
            end
         end
      end
      vectors++;
      if (exp_code == 2'd0 ? (done !== 1'b1 || core_hold !== 1'b0)
                           : (error !== 1'b1 || core_hold !== 1'b1 || in_ready !== 1'b0)) begin
         miscompares++;
         $display("FAIL %s terminal hold: got done/err/hold/ready %b%b%b%b", name, done, error,
                  core_hold, in_ready);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      vectors++;
      if ({in_ready, wr_en, core_hold, done, error, err_code} !== 7'b0010000) begin
         miscompares++;
         $display("FAIL reset flags ready/wr/hold/done/err/code: got %b%b%b%b%b%0d want 0010000",
                  in_ready, wr_en, core_hold, done, error, err_code);
      end
      vectors++;
      if ({wr_addr, wr_data, boot_pc} !== 96'd0) begin
         miscompares++;
         $display("FAIL reset buses: got addr %h data %h pc %h want 0", wr_addr, wr_data, boot_pc);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset in_ready rise: got %b want 1", in_ready);
      end
   endtask

   task automatic test_basic();
      img_words = '{32'h20080004, 32'h20090008};
      test_image("basic", 32'h000000C8, 16'd2, 1'b0, 1'b0);
      test_image("gaps", 32'h000000C8, 16'd2, 1'b1, 1'b0);
   endtask

   task automatic test_errors();
      img_words = '{32'h20080004, 32'h20090008};
      test_image("misaligned", 32'h000000CA, 16'd2, 1'b0, 1'b0);
      test_image("count_over", 32'h00000100, 16'h0401, 1'b0, 1'b0);
   endtask

   task automatic test_count_bounds();
      img_words.delete();
      test_image("count_zero", 32'h00000040, 16'd0, 1'b0, 1'b0);
      repeat (MaxW) img_words.push_back($urandom);
      test_image("count_max", 32'h00001000, 16'(MaxW), 1'b0, 1'b0);
   endtask

   task automatic test_wrap();
      img_words.delete();
      repeat (2) img_words.push_back($urandom);
      test_image("wrap", 32'hFFFFFFFC, 16'd2, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         img_words.delete();
         repeat ($urandom_range(1, 8)) img_words.push_back($urandom);
         test_image("random", {30'($urandom), 2'b00}, 16'(img_words.size()),
                    1'($urandom_range(0, 1)), 1'b0);
      end
   endtask

   task automatic test_restart();
      logic [7:0] csum;
      @(negedge clk);
      img_words = '{32'hA1A2A3A4, 32'hB1B2B3B4};
      pulse_start();
      for (int i = 3; i >= 0; i--) send_byte(8'(32'h00000100 >> (8 * i)), 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      for (int i = 0; i < 6; i++) send_byte(8'(img_words[i / 4] >> (8 * (3 - i % 4))), 1'b0);
      vectors++;
      if (got_data.size() != 1 || got_data[0] !== 32'hA1A2A3A4) begin
         miscompares++;
         $display("FAIL restart first word: got %0d writes want 1 of a1a2a3a4", got_data.size());
      end
      pulse_start();
      img_words = '{32'hC0DE0013};
      model(32'h00000200, 16'd1, 1'b0, csum);
      drive_image(32'h00000200, 16'd1, csum, 1'b0);
      @(negedge clk);
      vectors++;
      if ({done, core_hold, error} !== 3'b100 || boot_pc !== 32'h00000200) begin
         miscompares++;
         $display("FAIL restart release: got done/hold/err %b%b%b pc %h want 100 pc 200", done,
                  core_hold, error, boot_pc);
      end
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (got_addr.size() != 1) begin
         miscompares++;
         $display("FAIL restart write count: got %0d want 1", got_addr.size());
      end else begin
         vectors++;
         if (got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0]) begin
            miscompares++;
            $display("FAIL restart write: got (%h,%h) want (%h,%h)", got_addr[0], got_data[0],
                     exp_addr[0], exp_data[0]);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      pulse_start();
      for (int i = 3; i >= 0; i--) send_byte(8'(32'h00000040 >> (8 * i)), 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({in_ready, wr_en, core_hold, done} !== 4'b0010) begin
         miscompares++;
         $display("FAIL async reset flags ready/wr/hold/done: got %b%b%b%b want 0010", in_ready,
                  wr_en, core_hold, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      #1;
      vectors++;
      if (got_addr.size() != 0) begin
         miscompares++;
         $display("FAIL async reset partial word: got %0d writes want 0", got_addr.size());
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      img_words = '{32'h11223344};
      test_image("csum_good", 32'h00000080, 16'd1, 1'b0, 1'b0);
      test_image("csum_bad", 32'h00000080, 16'd1, 1'b0, 1'b1);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_errors();
      test_count_bounds();
      test_wrap();
      test_random();
      test_restart();
      test_async_reset();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
